// File: rtl/emd_pkg.sv
// rtl/emd_pkg.sv - shared EMD datapath types and sizing for the variable delay reader
package emd_pkg;

  localparam int DW            = 16;
  localparam int DEPTH         = 128;
  localparam int AW            = 7;
  localparam int DEFAULT_DELAY = 120;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic {FILL, RUN} state_t;

  // A zero delay would read the slot being written; the shortest usable delay is 1.
  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] d);
    return (d == '0) ? AW'(1) : d;
  endfunction

endpackage

// File: rtl/var_delay_reader_if.sv
// rtl/var_delay_reader_if.sv - sample stream, delay load and delayed output of the delay reader
interface var_delay_reader_if;
  import emd_pkg::*;

  sample_t       Xin;
  logic          Xin_vld;
  logic [AW-1:0] Delay;
  logic          Delay_ld;
  sample_t       Xout;
  logic          Xout_vld;
  logic          Filling;

  modport master (
    output Xin, Xin_vld, Delay, Delay_ld,
    input  Xout, Xout_vld, Filling
  );

  modport slave (
    input  Xin, Xin_vld, Delay, Delay_ld,
    output Xout, Xout_vld, Filling
  );

endinterface

// File: rtl/delay_ram_dp.sv
// rtl/delay_ram_dp.sv - simple dual-port RAM, one write port and one registered read port
module delay_ram_dp #(
  parameter int DW    = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto RAM primitives.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/var_delay_reader.sv
// rtl/var_delay_reader.sv - programmable-depth sample delay read side (option: VAR_DELAY_ZERO_FILL_EN)
module var_delay_reader
  import emd_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  var_delay_reader_if.slave bus
);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] d_reg;
  logic [AW-1:0] new_d;
  logic [AW-1:0] fill_nxt;
  logic [AW-1:0] rd_addr;
  logic          filling_r;
  logic          xout_vld_r;
  logic          out_zero;
  logic          run_rd;
  logic [DW-1:0] rd_data;

  assign new_d    = clamp_delay(bus.Delay);
  assign fill_nxt = fill_cnt + AW'(1);
  // A sample coinciding with a delay load belongs to the new fill, so it never reads.
  assign run_rd   = bus.Xin_vld && (state == RUN) && !bus.Delay_ld;
  assign rd_addr  = wptr - d_reg;

  delay_ram_dp #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .we    (bus.Xin_vld),
    .waddr (wptr),
    .wdata (bus.Xin),
    .re    (run_rd),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= FILL;
      wptr       <= '0;
      fill_cnt   <= '0;
      d_reg      <= AW'(DEFAULT_DELAY);
      filling_r  <= 1'b1;
      xout_vld_r <= 1'b0;
      out_zero   <= 1'b1;
    end else begin
      if (bus.Xin_vld) wptr <= wptr + AW'(1);

      if (bus.Delay_ld) begin
        d_reg    <= new_d;
        fill_cnt <= bus.Xin_vld ? AW'(1) : '0;
        if (bus.Xin_vld && new_d == AW'(1)) begin
          state     <= RUN;
          filling_r <= 1'b0;
        end else begin
          state     <= FILL;
          filling_r <= 1'b1;
        end
      end else if (state == FILL && bus.Xin_vld) begin
        fill_cnt <= fill_nxt;
        if (fill_nxt == d_reg) begin
          state     <= RUN;
          filling_r <= 1'b0;
        end
      end

`ifdef VAR_DELAY_ZERO_FILL_EN
      // Every accepted sample emits; samples without a RAM read emit zero.
      xout_vld_r <= bus.Xin_vld;
      if (bus.Xin_vld) out_zero <= !run_rd;
`else
      xout_vld_r <= run_rd;
      if (run_rd) out_zero <= 1'b0;
`endif
    end
  end

  // The RAM read register holds between reads; out_zero covers reset and zero-fill.
  assign bus.Xout     = out_zero ? '0 : rd_data;
  assign bus.Xout_vld = xout_vld_r;
  assign bus.Filling  = filling_r;

endmodule

// File: tb/tb_var_delay_reader.sv
// tb/tb_var_delay_reader.sv - directed self-checking bench for var_delay_reader
module tb_var_delay_reader;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;
  logic [15:0] exp_last;

  var_delay_reader_if bus();

  var_delay_reader dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle; outputs are checked 1 time unit after the clock edge.
  task automatic cycle(input bit vld, input logic [15:0] x, input bit ld, input logic [6:0] d,
                       input bit exp_vld, input logic [15:0] exp_x, input string tag);
    bit       ev;
    logic [15:0] ex;
    bus.Xin_vld  = vld;
    bus.Xin      = x;
    bus.Delay_ld = ld;
    bus.Delay    = d;
    @(posedge CLK);
    #1;
    bus.Xin_vld  = 1'b0;
    bus.Delay_ld = 1'b0;
    ev = exp_vld;
    ex = exp_x;
`ifdef VAR_DELAY_ZERO_FILL_EN
    if (vld && !ev) begin
      ev = 1'b1;
      ex = 16'd0;
    end
`endif
    if (ev) exp_last = ex;
    check({tag, ".vld"}, {31'd0, bus.Xout_vld}, {31'd0, ev});
    check({tag, ".xout"}, {16'd0, bus.Xout}, {16'd0, exp_last});
  endtask

  task automatic push(input logic [15:0] x, input bit exp_vld, input logic [15:0] exp_x, input string tag);
    cycle(1'b1, x, 1'b0, 7'd0, exp_vld, exp_x, tag);
  endtask

  logic [15:0] hist [$];
  int accepted;
  int outs;
  bit v;
  logic [15:0] xv;

  initial begin
    checks   = 0;
    failures = 0;
    exp_last = 16'd0;
    RST_N        = 1'b0;
    bus.Xin      = '0;
    bus.Xin_vld  = 1'b0;
    bus.Delay    = '0;
    bus.Delay_ld = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.xout", {16'd0, bus.Xout}, 32'd0);
    check("rst.vld", {31'd0, bus.Xout_vld}, 32'd0);
    check("rst.filling", {31'd0, bus.Filling}, 32'd1);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Default delay 120: silent for 120 samples, then Xout = Xin - 120.
    for (int i = 1; i <= 120; i++) begin
      push(16'(i), 1'b0, 16'd0, $sformatf("t1.fill%0d", i));
      if (i == 119) check("t1.filling119", {31'd0, bus.Filling}, 32'd1);
    end
    check("t1.filling120", {31'd0, bus.Filling}, 32'd0);
    for (int i = 121; i <= 130; i++) push(16'(i), 1'b1, 16'(i - 120), $sformatf("t1.run%0d", i));

    // Load delay 5 with no sample.
    cycle(1'b0, 16'd0, 1'b1, 7'd5, 1'b0, 16'd0, "t2.load");
    check("t2.filling", {31'd0, bus.Filling}, 32'd1);
    for (int i = 131; i <= 135; i++) push(16'(i), 1'b0, 16'd0, $sformatf("t2.fill%0d", i));
    check("t2.filling_end", {31'd0, bus.Filling}, 32'd0);
    push(16'd136, 1'b1, 16'd131, "t2.first");
    push(16'd137, 1'b1, 16'd132, "t2.second");

    // Coincident load of delay 3 with sample 200: 200 is fill #1.
    cycle(1'b1, 16'd200, 1'b1, 7'd3, 1'b0, 16'd0, "t3.coinc");
    check("t3.filling", {31'd0, bus.Filling}, 32'd1);
    push(16'd201, 1'b0, 16'd0, "t3.fill2");
    push(16'd202, 1'b0, 16'd0, "t3.fill3");
    push(16'd203, 1'b1, 16'd200, "t3.first");
    push(16'd204, 1'b1, 16'd201, "t3.second");
    cycle(1'b0, 16'd0, 1'b0, 7'd0, 1'b0, 16'd0, "t3.hold");

    // Delay 0 clamps to 1.
    cycle(1'b0, 16'd0, 1'b1, 7'd0, 1'b0, 16'd0, "t4.load0");
    push(16'd300, 1'b0, 16'd0, "t4.fill");
    push(16'd301, 1'b1, 16'd300, "t4.d1a");
    push(16'd302, 1'b1, 16'd301, "t4.d1b");

    // Delay 127: the 136 pushes below cross the pointer wrap.
    cycle(1'b0, 16'd0, 1'b1, 7'd127, 1'b0, 16'd0, "t4.load127");
    for (int i = 0; i < 127; i++) push(16'(1000 + i), 1'b0, 16'd0, $sformatf("t4.fill%0d", i));
    for (int i = 127; i < 136; i++) push(16'(1000 + i), 1'b1, 16'(1000 + i - 127), $sformatf("t4.run%0d", i));

    // Delay 10 with random gaps.
    cycle(1'b0, 16'd0, 1'b1, 7'd10, 1'b0, 16'd0, "t5.load");
    accepted = 0;
    outs     = 0;
    for (int c = 0; c < 200; c++) begin
      v  = 1'($urandom_range(0, 1));
      xv = 16'($urandom);
      if (v) begin
        hist.push_back(xv);
        if (accepted >= 10) cycle(1'b1, xv, 1'b0, 7'd0, 1'b1, hist[accepted - 10], $sformatf("t5.s%0d", accepted));
        else cycle(1'b1, xv, 1'b0, 7'd0, 1'b0, 16'd0, $sformatf("t5.f%0d", accepted));
        accepted++;
      end else begin
        cycle(1'b0, xv, 1'b0, 7'd0, 1'b0, 16'd0, $sformatf("t5.gap%0d", c));
      end
      if (bus.Xout_vld) outs++;
    end
`ifdef VAR_DELAY_ZERO_FILL_EN
    check("t5.count", 32'(outs), 32'(accepted));
`else
    check("t5.count", 32'(outs), (accepted >= 10) ? 32'(accepted - 10) : 32'd0);
`endif

    // Asynchronous reset mid-run, then default delay from scratch.
    push(16'd555, 1'b1, hist[accepted - 10], "t6.pre");
    #2;
    RST_N = 1'b0;
    #1;
    check("t6.rst_xout", {16'd0, bus.Xout}, 32'd0);
    check("t6.rst_vld", {31'd0, bus.Xout_vld}, 32'd0);
    check("t6.rst_filling", {31'd0, bus.Filling}, 32'd1);
    exp_last = 16'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 120; i++) push(16'(2000 + i), 1'b0, 16'd0, $sformatf("t6.fill%0d", i));
    push(16'd2120, 1'b1, 16'd2000, "t6.first");
    push(16'd2121, 1'b1, 16'd2001, "t6.second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
